// File: rtl/phase_sequencer.sv
// Phase sequencer: generates one-hot fetch/exec1/exec2/exec3 strobes for the
// decoder, with run/halt/single-step debug control, PC breakpoint and counters.
module phase_sequencer #(
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16,
  parameter int START_HALTED = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic             extra,
  input  logic             extra2,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             exec3,
  output logic             instr_done,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_EXEC3 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   step_mode;
  logic   skip_bp;
  logic   bp_match;

  // Strobes are masked while reset is asserted so an abandoned instruction
  // produces nothing further.
  always_comb begin
    bp_match   = bp_en && (pc == bp_addr) && !skip_bp;
    fetch      = reset_n && (state == S_FETCH) && mem_ready && !halt_req && !bp_match;
    exec1      = reset_n && (state == S_EXEC1) && mem_ready;
    exec2      = reset_n && (state == S_EXEC2) && mem_ready;
    exec3      = reset_n && (state == S_EXEC3) && mem_ready;
    instr_done = (exec1 && !extra) || (exec2 && !extra2) || exec3;
    halted     = (state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= (START_HALTED != 0) ? S_HALT : S_FETCH;
      step_mode   <= 1'b0;
      skip_bp     <= 1'b1;
      bp_hit      <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != S_HALT)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if (instr_done)
        retired_cnt <= retired_cnt + CNT_ONE;

      case (state)
        S_HALT: begin
          if (!halt_req && (run || step)) begin
            state     <= S_FETCH;
            step_mode <= !run;
            skip_bp   <= 1'b1;
            bp_hit    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (halt_req) begin
            state <= S_HALT;
          end else if (bp_match) begin
            state  <= S_HALT;
            bp_hit <= 1'b1;
          end else if (mem_ready) begin
            state   <= S_EXEC1;
            skip_bp <= 1'b0;
          end
        end
        S_EXEC1, S_EXEC2, S_EXEC3: begin
          // Exec phases only advance on a ready cycle; instr_done already
          // folds in mem_ready and the extra/extra2 length decision.
          if (instr_done) begin
            state     <= step_mode ? S_HALT : S_FETCH;
            step_mode <= 1'b0;
          end else if (exec1) begin
            state <= S_EXEC2;
          end else if (exec2) begin
            state <= S_EXEC3;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Control-unit state machine that generates the one-hot fetch/exec1/exec2/exec3 phase strobes consumed by the instruction decoder.
- Instruction length comes from the decoder's extra/extra2 outputs. Phases are frozen on memory wait-states.
- Adds run/halt/single-step debug control, a PC breakpoint, and cycle/retired-instruction counters.
- Sits between the debug/front-panel logic and the decoder, one instance per CPU.

Parameters:
PC_W, 8, width of pc and bp_addr
CNT_W, 16, width of cycle_cnt and retired_cnt
START_HALTED, 0, 1 = leave reset in HALT; 0 = leave reset in FETCH

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
run  in  1  level; leave HALT and run freely
step  in  1  level; leave HALT and execute exactly one instruction
halt_req  in  1  level; stop at next instruction boundary
mem_ready  in  1  0 = memory wait-state, hold current phase
extra  in  1  from decoder: instruction needs exec2
extra2  in  1  from decoder: instruction needs exec3
pc  in  PC_W  current program counter value
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
fetch  out  1  fetch phase strobe
exec1  out  1  exec1 phase strobe
exec2  out  1  exec2 phase strobe
exec3  out  1  exec3 phase strobe
instr_done  out  1  one-cycle pulse on the final phase of each instruction
halted  out  1  state == HALT
bp_hit  out  1  sticky; halt was caused by breakpoint
cycle_cnt  out  CNT_W  non-halted cycle count
retired_cnt  out  CNT_W  completed instruction count

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Reset values:
  - State is HALT if START_HALTED = 1, else FETCH.
  - All strobes and instr_done = 0; bp_hit = 0.
  - Counters = 0; step_mode = 0; skip_bp = 1.
  - Reset mid-instruction abandons it: no instr_done, no further strobes.
- States: HALT, FETCH, EXEC1, EXEC2, EXEC3 (binary encoded internally).
- Strobes are combinational from registered state:
  - A strobe = (state == that phase) & mem_ready.
  - At most one strobe is high per cycle. All are 0 in HALT and during stalls.
- Stall: mem_ready = 0 in any phase state holds the state. Counters other than cycle_cnt hold.
- FETCH evaluation, priority order:
  1. halt_req = 1: go to HALT; no fetch strobe, regardless of mem_ready.
  2. bp_en & pc == bp_addr & !skip_bp: go to HALT, set bp_hit; no fetch strobe.
  3. Otherwise, if mem_ready: strobe fetch, clear skip_bp, go to EXEC1.
- Exec phase transitions (each taken only when mem_ready = 1):
  - EXEC1 goes to EXEC2 if extra, else the instruction ends.
  - EXEC2 goes to EXEC3 if extra2, else the instruction ends.
  - EXEC3: the instruction always ends.
- Instruction end:
  - instr_done = 1 in that cycle; retired_cnt increments.
  - Next state is HALT if step_mode, else FETCH.
  - step_mode clears at the end.
  - extra/extra2 are sampled only in the cycle they decide the transition.
- HALT exit: requires halt_req = 0.
  - run = 1: go to FETCH, step_mode = 0.
  - Else step = 1: go to FETCH, step_mode = 1.
  - run has priority over step.
  - On exit: skip_bp = 1, bp_hit clears.
  - run/step are level inputs: a held step re-steps every time HALT is re-entered.
- halt_req is never taken mid-instruction; it is honoured only in FETCH.
- skip_bp lets execution resume from a breakpoint address without re-triggering.
- Counters:
  - cycle_cnt increments every cycle state != HALT, stalls included.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Latency:
  - HALT to fetch strobe: 1 cycle after run is sampled.
  - One-cycle instruction: 2 cycles (fetch, exec1) with mem_ready held high.

Test Plan:
- Reset with START_HALTED=0, mem_ready=1, extra=0: fetch at cycle 0, exec1 at cycle 1, instr_done at cycle 1, fetch again at cycle 2; retired_cnt=3 after 6 cycles.
- extra=1, extra2=1: strobe sequence fetch, exec1, exec2, exec3, fetch; instr_done only with exec3. Then drop extra2: sequence ends at exec2.
- mem_ready=0 for 3 cycles in EXEC2: no strobes, state held, cycle_cnt +3, retired_cnt unchanged; exec2 strobes on the first ready cycle.
- halt_req raised during exec1 of a 3-phase instruction: exec2 and exec3 still occur, then halted=1 with no fetch. Pulse step with halt_req=0: exactly one instruction executes (one instr_done), then halted=1.
- bp_en=1, bp_addr=0x05, pc reaches 0x05: halted=1, bp_hit=1, no fetch. run=1: fetch at pc 0x05 with no re-halt, bp_hit clears.
- CNT_W=4: after 16 retired instructions retired_cnt=0. reset_n=0 during EXEC2: next cycle state FETCH and all counters zero.
